// File: rtl/fb_io_ctrl.sv
// Memory-mapped terminal controller: keyboard receive FIFO, display valid/ack sender, sticky status.
// Optional: define FB_IO_IRQ_EN to add the registered irq output and the tx_done status bit.
module fb_io_ctrl #(
    parameter int unsigned KBD_DEPTH = 4,
    parameter int unsigned PTR_W     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_sel,
    input  logic [1:0]  io_add,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [7:0]  io_wdata,
    output logic [31:0] io_rdata,
    input  logic        clr_stat,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ack
`ifdef FB_IO_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [0:0] {StIdle, StSend} tx_state_e;

    tx_state_e        r_state, w_state_d;
    logic [7:0]       r_mem [KBD_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_rx_ovf, r_tx_drop;
    logic [7:0]       r_disp_data, w_disp_data_d;

    logic             w_full, w_rx_avail, w_tx_busy;
    logic             w_pop, w_push, w_data_wr;
    logic [7:0]       w_head;
    logic [3:0]       w_cnt4;
    logic [31:0]      w_status;

    assign w_full     = (r_count == (PTR_W+1)'(KBD_DEPTH));
    assign w_rx_avail = (r_count != '0);
    assign w_tx_busy  = (r_state != StIdle);
    assign w_pop      = io_sel & io_rd & (io_add == 2'b10) & w_rx_avail;
    // Fullness is judged before any same-cycle pop, so a full FIFO never admits a push.
    assign w_push     = kbd_valid & ~w_full;
    assign w_data_wr  = io_sel & io_wr & (io_add == 2'b01);
    assign w_head     = w_rx_avail ? r_mem[r_rd_ptr] : 8'h00;
    assign w_cnt4     = 4'(r_count);

    assign kbd_ready  = ~w_full;
    assign disp_valid = (r_state == StSend);
    assign disp_data  = r_disp_data;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= kbd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_ovf  <= 1'b0;
            r_tx_drop <= 1'b0;
        end else begin
            r_rx_ovf  <= (kbd_valid & w_full) | (r_rx_ovf & ~clr_stat);
            r_tx_drop <= (w_data_wr & w_tx_busy) | (r_tx_drop & ~clr_stat);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_disp_data <= 8'h00;
        end else begin
            r_state     <= w_state_d;
            r_disp_data <= w_disp_data_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_disp_data_d = r_disp_data;
        unique case (r_state)
            StIdle: begin
                if (w_data_wr) begin
                    w_state_d     = StSend;
                    w_disp_data_d = io_wdata;
                end
            end
            StSend: begin
                if (disp_ack) w_state_d = StIdle;
            end
        endcase
    end

`ifdef FB_IO_IRQ_EN
    logic r_tx_done, r_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_done <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if ((r_state == StSend) && disp_ack) r_tx_done <= 1'b1;
            else if (clr_stat || w_data_wr)      r_tx_done <= 1'b0;
            r_irq <= w_rx_avail | r_rx_ovf | r_tx_done;
        end
    end

    assign irq      = r_irq;
    assign w_status = {23'b0, w_cnt4, r_tx_done, r_tx_drop, r_rx_ovf, w_tx_busy, w_rx_avail};
`else
    assign w_status = {24'b0, w_cnt4, r_tx_drop, r_rx_ovf, w_tx_busy, w_rx_avail};
`endif

    always_comb begin
        io_rdata = 32'h0;
        if (io_sel) begin
            case (io_add)
                2'b00:   io_rdata = w_status;
                2'b01:   io_rdata = {24'b0, r_disp_data};
                2'b10:   io_rdata = {24'b0, w_head};
                default: io_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_io_ctrl.sv
// Self-checking bench for fb_io_ctrl: directed scenarios plus randomized traffic vs a queue model.
module tb_fb_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_sel, io_rd, io_wr, clr_stat, kbd_valid, disp_ack;
    logic [1:0]  io_add;
    logic [7:0]  io_wdata, kbd_data;
    logic [31:0] io_rdata;
    logic        kbd_ready, disp_valid;
    logic [7:0]  disp_data;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: FIFO as a queue, handshake as a busy flag.
    logic [7:0] mq[$];
    bit         m_ovf, m_drop, m_busy;
    logic [7:0] m_disp;

    fb_io_ctrl #(.KBD_DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .io_sel(io_sel), .io_add(io_add), .io_rd(io_rd), .io_wr(io_wr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .clr_stat(clr_stat), .kbd_valid(kbd_valid),
        .kbd_data(kbd_data), .kbd_ready(kbd_ready), .disp_valid(disp_valid),
        .disp_data(disp_data), .disp_ack(disp_ack)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        mq.delete();
        m_ovf  = 0;
        m_drop = 0;
        m_busy = 0;
        m_disp = 8'h00;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [3:0] cnt;
        cnt = 4'(mq.size());
        return {24'b0, cnt, m_drop, m_ovf, m_busy, (mq.size() != 0)};
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (!io_sel) return 32'h0;
        case (io_add)
            2'd0:    return exp_status();
            2'd1:    return {24'b0, m_disp};
            2'd2:    return (mq.size() != 0) ? {24'b0, mq[0]} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_step();
        bit was_full, dwr;
        was_full = (mq.size() == 4);
        dwr      = io_sel && io_wr && (io_add == 2'd1);
        if (io_sel && io_rd && io_add == 2'd2 && mq.size() != 0) void'(mq.pop_front());
        if (kbd_valid && !was_full) mq.push_back(kbd_data);
        m_ovf  = (kbd_valid && was_full) || (m_ovf && !clr_stat);
        m_drop = (dwr && m_busy) || (m_drop && !clr_stat);
        if (m_busy) begin
            if (disp_ack) m_busy = 0;
        end else if (dwr) begin
            m_busy = 1;
            m_disp = io_wdata;
        end
    endfunction

    task automatic idle();
        io_sel = 0; io_add = 0; io_rd = 0; io_wr = 0; io_wdata = 0;
        clr_stat = 0; kbd_valid = 0; kbd_data = 0; disp_ack = 0;
    endtask

    // Inputs are driven after negedge; the model advances at the same posedge as the DUT.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        idle();
    endtask

    task automatic read_status();
        io_sel = 1; io_rd = 1; io_add = 2'd0;
    endtask

    task automatic test_reset();
        kbd_valid = 1; kbd_data = 8'h77;
        tick();
        io_sel = 1; io_wr = 1; io_add = 2'd1; io_wdata = 8'h5A;
        tick();
        n_cmp++;
        if (disp_valid !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_valid: got %b want 1", disp_valid);
        end
        read_status();
        #2 rst = 1;
        model_reset();
        #1;
        n_cmp++;
        if (disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", disp_valid);
        end
        n_cmp++;
        if (io_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_status: got %h want 0", io_rdata);
        end
        n_cmp++;
        if (kbd_ready !== 1'b1 || disp_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_ready_data: got %b/%h want 1/00", kbd_ready, disp_data);
        end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_keyboard();
        kbd_valid = 1; kbd_data = 8'h41; tick();
        kbd_valid = 1; kbd_data = 8'h42; tick();
        read_status(); #1;
        n_cmp++;
        if (io_rdata !== 32'h21) begin
            n_fail++; $display("FAIL kbd_status2: got %h want 21", io_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] want;
            want = (i == 0) ? 32'h41 : (i == 1) ? 32'h42 : 32'h0;
            io_sel = 1; io_rd = 1; io_add = 2'd2; #1;
            n_cmp++;
            if (io_rdata !== want || io_rdata !== exp_rdata()) begin
                n_fail++; $display("FAIL kbd_pop%0d: got %h want %h", i, io_rdata, want);
            end
            tick();
            if (i == 1) begin
                read_status(); #1;
                n_cmp++;
                if (io_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL kbd_empty_status: got %h want 0", io_rdata);
                end
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            kbd_valid = 1; kbd_data = 8'h60 + 8'(i); tick();
            if (i == 3) begin
                n_cmp++;
                if (kbd_ready !== 1'b0) begin
                    n_fail++; $display("FAIL ovf_ready: got %b want 0", kbd_ready);
                end
            end
        end
        read_status(); #1;
        n_cmp++;
        if (io_rdata !== 32'h45) begin
            n_fail++; $display("FAIL ovf_status: got %h want 45", io_rdata);
        end
        clr_stat = 1; tick();
        read_status(); #1;
        n_cmp++;
        if (io_rdata !== 32'h41) begin
            n_fail++; $display("FAIL ovf_cleared: got %h want 41", io_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            io_sel = 1; io_rd = 1; io_add = 2'd2; #1;
            n_cmp++;
            if (io_rdata !== 32'h60 + 32'(i)) begin
                n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", i, io_rdata, 32'h60 + i);
            end
            tick();
        end
    endtask

    task automatic test_display();
        io_sel = 1; io_wr = 1; io_add = 2'd1; io_wdata = 8'h55; tick();
        for (int i = 0; i < 3; i++) begin
            read_status(); #1;
            n_cmp++;
            if (disp_valid !== 1'b1 || disp_data !== 8'h55 || io_rdata[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL disp_hold%0d: got %b/%h/%h want 1/55/busy", i, disp_valid,
                         disp_data, io_rdata);
            end
            tick();
        end
        io_sel = 1; io_wr = 1; io_add = 2'd1; io_wdata = 8'h66; tick();
        read_status(); #1;
        n_cmp++;
        if (disp_data !== 8'h55 || io_rdata[3] !== 1'b1) begin
            n_fail++; $display("FAIL disp_drop: got %h/%h want 55/drop", disp_data, io_rdata);
        end
        clr_stat = 1; io_sel = 1; io_wr = 1; io_add = 2'd1; io_wdata = 8'h67; tick();
        read_status(); #1;
        n_cmp++;
        if (io_rdata[3] !== 1'b1 || io_rdata !== exp_status()) begin
            n_fail++; $display("FAIL drop_set_wins: got %h want %h", io_rdata, exp_status());
        end
        disp_ack = 1; tick();
        n_cmp++;
        if (disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL disp_ack: got %b want 0", disp_valid);
        end
        clr_stat = 1; tick();
    endtask

    task automatic test_back_to_back();
        io_sel = 1; io_wr = 1; io_add = 2'd1; io_wdata = 8'h11; tick();
        disp_ack = 1; io_sel = 1; io_wr = 1; io_add = 2'd1; io_wdata = 8'h22; tick();
        read_status(); #1;
        n_cmp++;
        if (disp_valid !== 1'b0 || disp_data !== 8'h11 || io_rdata !== 32'h08) begin
            n_fail++;
            $display("FAIL b2b_ackcycle: got %b/%h/%h want 0/11/08", disp_valid, disp_data, io_rdata);
        end
        io_sel = 1; io_wr = 1; io_add = 2'd1; io_wdata = 8'h33; tick();
        n_cmp++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h33) begin
            n_fail++; $display("FAIL b2b_next: got %b/%h want 1/33", disp_valid, disp_data);
        end
        disp_ack = 1; clr_stat = 1; tick();
    endtask

    task automatic test_full_pushpop();
        for (int r = 0; r < 10; r++) begin
            while (mq.size() < 4) begin
                kbd_valid = 1; kbd_data = 8'($urandom); tick();
            end
            kbd_valid = 1; kbd_data = 8'hEE; io_sel = 1; io_rd = 1; io_add = 2'd2; #1;
            n_cmp++;
            if (io_rdata !== exp_rdata()) begin
                n_fail++; $display("FAIL full_pop_head%0d: got %h want %h", r, io_rdata, exp_rdata());
            end
            tick();
            read_status(); #1;
            n_cmp++;
            if (io_rdata[7:4] !== 4'd3 || io_rdata[2] !== 1'b1) begin
                n_fail++; $display("FAIL full_pushpop%0d: got %h want cnt3 ovf1", r, io_rdata);
            end
            clr_stat = 1; tick();
            while (mq.size() > 0) begin
                io_sel = 1; io_rd = 1; io_add = 2'd2; #1;
                n_cmp++;
                if (io_rdata !== exp_rdata()) begin
                    n_fail++; $display("FAIL drain%0d: got %h want %h", r, io_rdata, exp_rdata());
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            io_sel    = ($urandom_range(3) != 0);
            io_add    = 2'($urandom);
            io_rd     = 1'($urandom);
            io_wr     = ($urandom_range(3) == 0);
            io_wdata  = 8'($urandom);
            clr_stat  = ($urandom_range(7) == 0);
            kbd_valid = ($urandom_range(2) == 0);
            kbd_data  = 8'($urandom);
            disp_ack  = ($urandom_range(2) == 0);
            #1;
            n_cmp++;
            if (io_rdata !== exp_rdata()) begin
                n_fail++; $display("FAIL rand_rdata@%0d: got %h want %h", c, io_rdata, exp_rdata());
            end
            n_cmp++;
            if (disp_valid !== m_busy || disp_data !== m_disp || kbd_ready !== (mq.size() < 4)) begin
                n_fail++;
                $display("FAIL rand_outs@%0d: got %b/%h/%b want %b/%h/%b", c, disp_valid, disp_data,
                         kbd_ready, m_busy, m_disp, mq.size() < 4);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        rst = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        read_status(); #1;
        n_cmp++;
        if (io_rdata !== 32'h0 || kbd_ready !== 1'b1 || disp_valid !== 1'b0) begin
            n_fail++; $display("FAIL init_state: got %h/%b/%b want 0/1/0", io_rdata, kbd_ready,
                               disp_valid);
        end
        tick();
        test_reset();
        test_keyboard();
        test_overflow();
        test_display();
        test_back_to_back();
        test_full_pushpop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
